multdiv_unit: RTL

Iterative signed 32-bit multiply/divide unit with architectural HI/LO registers. It sits in the execute stage, directly downstream of the main decoder, and consumes that decoder's `multdiv` and `hilo` controls for `mult`, `div`, `mfhi` and `mflo`. It raises `stall` so the hazard logic freezes the front of the pipeline while a result is pending.

---
 rtl/multdiv_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_unit
// Purpose  : Iterative signed 32x32 multiply / 32/32 divide with HI/LO
//            registers. One iteration per cycle over unsigned magnitudes;
//            signs are applied when the result is written back.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isdiv,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [1:0]  hilo,
  output logic [31:0] hilo_out,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] C_LAST_ITER = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        isdiv_q, isdiv_d;
  logic [31:0] orig_a_q, orig_a_d;   // raw dividend, returned in HI on divide-by-zero
  logic        sign_q, sign_d;       // product / quotient sign
  logic        rsign_q, rsign_d;     // remainder sign follows the dividend
  logic [31:0] bmag_q, bmag_d;       // |srcb|: multiplicand or divisor
  logic [63:0] acc_q, acc_d;         // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand magnitudes; 0x80000000 negates to itself and is read as unsigned 2^31.
  logic [31:0] amag, bmag_in;
  always_comb begin
    amag    = srca[31] ? (~srca + 32'd1) : srca;
    bmag_in = srcb[31] ? (~srcb + 32'd1) : srcb;
  end

  // One shift-add multiply step and one restoring-divide step over the accumulator.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bmag_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, bmag_q});
    div_diff  = div_shift - {1'b0, bmag_q};
    div_next  = div_ge ? {div_diff[31:0],  acc_q[30:0], 1'b1}
                       : {div_shift[31:0], acc_q[30:0], 1'b0};
  end

  // Signed results recovered from the final unsigned accumulator.
  logic [63:0] prod_signed;
  logic [31:0] quot_signed;
  logic [31:0] rem_signed;
  always_comb begin
    prod_signed = sign_q  ? (~acc_q + 64'd1)          : acc_q;
    quot_signed = sign_q  ? (~acc_q[31:0]  + 32'd1)   : acc_q[31:0];
    rem_signed  = rsign_q ? (~acc_q[63:32] + 32'd1)   : acc_q[63:32];
  end

  // Next-state and datapath update: accept in IDLE, iterate in RUN, write back in DONE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    isdiv_d  = isdiv_q;
    orig_a_d = orig_a_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          count_d  = 5'd0;
          isdiv_d  = isdiv;
          orig_a_d = srca;
          sign_d   = srca[31] ^ srcb[31];
          rsign_d  = srca[31];
          bmag_d   = bmag_in;
          acc_d    = {32'd0, amag};
        end
      end
      RUN: begin
        acc_d   = isdiv_q ? div_next : mul_next;
        count_d = count_q + 5'd1;
        if (count_q == C_LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (isdiv_q) begin
          if (bmag_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = orig_a_q;
          end else begin
            lo_d = quot_signed;
            hi_d = rem_signed;
          end
        end else begin
          hi_d = prod_signed[63:32];
          lo_d = prod_signed[31:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 5'd0;
      isdiv_q  <= 1'b0;
      orig_a_q <= 32'd0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      bmag_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      isdiv_q  <= isdiv_d;
      orig_a_q <= orig_a_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      bmag_q   <= bmag_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status, hazard stall and HI/LO read mux, all combinational from the registers.
  always_comb begin
    busy  = (state_q != IDLE);
    stall = busy & (start | (hilo != 2'b00));
    hi    = hi_q;
    lo    = lo_q;
    case (hilo)
      2'b10:   hilo_out = hi_q;
      2'b01:   hilo_out = lo_q;
      default: hilo_out = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
